// File: rtl/sampling_control_mc.sv
// -----------------------------------------------------------------------------
// sampling_control_mc
//
// Button-driven sampling controller for the DDS capture path. The raw front
// panel button is synchronised and debounced, then split into short-press and
// long-press events. A short press in IDLE steps the sampling mode. A long
// press starts a capture run (or aborts one in progress). A run issues Len_i+1
// one-clock Enable strobes spaced Div_i+1 clocks apart. It then raises Done
// and waits for Ack_i.
//
// Optional feature macro: SAMPLING_CONTROL_DEBOUNCE_EN
//   defined   : a DEB_CYCLES stability-window debouncer follows the synchroniser
//   undefined : the synchroniser output is used directly as the button level
//
// Ports
//   Fg_CLK  in   system clock, rising edge
//   RESETn  in   asynchronous active-low reset
//   IntBTN  in   raw asynchronous button, active high
//   Div_i   in   sample period minus 1 (clocks), latched at run start
//   Len_i   in   samples per run minus 1, latched at run start
//   Ack_i   in   downstream acknowledge of Done
//   Ready   out  high while idle
//   Enable  out  one-clock sample strobe
//   Done    out  run complete, held until acknowledged
//   Mode    out  current sampling mode
// -----------------------------------------------------------------------------
module sampling_control_mc #(
    parameter int N_MODES     = 4,
    parameter int MODE_W      = 2,
    parameter int DEB_CYCLES  = 16,
    parameter int LONG_CYCLES = 1024,
    parameter int DIV_W       = 16,
    parameter int CNT_W       = 10
) (
    input  logic              Fg_CLK,
    input  logic              RESETn,
    input  logic              IntBTN,
    input  logic [DIV_W-1:0]  Div_i,
    input  logic [CNT_W-1:0]  Len_i,
    input  logic              Ack_i,
    output logic              Ready,
    output logic              Enable,
    output logic              Done,
    output logic [MODE_W-1:0] Mode
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SAMPLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int                TMR_W     = $clog2(LONG_CYCLES + 1);
    localparam logic [TMR_W-1:0]  TMR_LONG  = TMR_W'(LONG_CYCLES);
    localparam logic [TMR_W-1:0]  TMR_FIRE  = TMR_W'(LONG_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_ONE   = TMR_W'(1'b1);
    localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(N_MODES - 1);
    localparam logic [MODE_W-1:0] MODE_ONE  = MODE_W'(1'b1);
    localparam logic [DIV_W-1:0]  DIV_ONE   = DIV_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);

    logic              sync1_r;
    logic              sync2_r;
    logic              deb_s;
    logic              deb_prev_r;
    logic [TMR_W-1:0]  press_tmr_r;
    logic              long_s;
    logic              short_s;

    logic [1:0]        state_r,    state_n;
    logic [DIV_W-1:0]  div_cnt_r,  div_cnt_n;
    logic [CNT_W-1:0]  samp_cnt_r, samp_cnt_n;
    logic              last_r,     last_n;
    logic [DIV_W-1:0]  div_lat_r,  div_lat_n;
    logic [CNT_W-1:0]  len_lat_r,  len_lat_n;
    logic [MODE_W-1:0] mode_r,     mode_n;
    logic              enable_n;
    logic              ready_r;
    logic              enable_r;
    logic              done_r;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= IntBTN;
            sync2_r <= sync1_r;
        end
    end

`ifdef SAMPLING_CONTROL_DEBOUNCE_EN
    localparam int               DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1'b1);

    logic [DEB_W-1:0] deb_cnt_r;
    logic             deb_lvl_r;

    // Debouncer: level follows the input only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            deb_cnt_r <= {DEB_W{1'b0}};
            deb_lvl_r <= 1'b0;
        end else if (sync2_r != deb_lvl_r) begin
            if (deb_cnt_r == DEB_LAST) begin
                deb_cnt_r <= {DEB_W{1'b0}};
                deb_lvl_r <= sync2_r;
            end else begin
                deb_cnt_r <= deb_cnt_r + DEB_ONE;
                deb_lvl_r <= deb_lvl_r;
            end
        end else begin
            deb_cnt_r <= {DEB_W{1'b0}};
            deb_lvl_r <= deb_lvl_r;
        end
    end

    assign deb_s = deb_lvl_r;
`else
    assign deb_s = sync2_r;
`endif

    // Press timer: counts debounced-high clocks and saturates at LONG_CYCLES
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            deb_prev_r  <= 1'b0;
            press_tmr_r <= {TMR_W{1'b0}};
        end else begin
            deb_prev_r <= deb_s;
            if (!deb_s) begin
                press_tmr_r <= {TMR_W{1'b0}};
            end else if (press_tmr_r != TMR_LONG) begin
                press_tmr_r <= press_tmr_r + TMR_ONE;
            end else begin
                press_tmr_r <= press_tmr_r;
            end
        end
    end

    // The timer passes LONG_CYCLES-1 exactly once per press, so long_s is a single pulse.
    // A saturated timer at release means the long event already fired: no short event.
    assign long_s  = deb_s & (press_tmr_r == TMR_FIRE);
    assign short_s = deb_prev_r & ~deb_s & (press_tmr_r != TMR_LONG);

    // Next-state logic for the run controller, divider, sample counter and mode
    always_comb begin
        state_n    = state_r;
        div_cnt_n  = div_cnt_r;
        samp_cnt_n = samp_cnt_r;
        last_n     = last_r;
        div_lat_n  = div_lat_r;
        len_lat_n  = len_lat_r;
        mode_n     = mode_r;
        enable_n   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (long_s) begin
                    state_n    = ST_SAMPLE;
                    div_lat_n  = Div_i;
                    len_lat_n  = Len_i;
                    div_cnt_n  = {DIV_W{1'b0}};
                    samp_cnt_n = {CNT_W{1'b0}};
                    last_n     = 1'b0;
                end else if (short_s) begin
                    mode_n = (mode_r == MODE_LAST) ? {MODE_W{1'b0}} : (mode_r + MODE_ONE);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SAMPLE: begin
                if (long_s) begin
                    // Abort wins over any strobe due this cycle
                    state_n = ST_IDLE;
                end else if (last_r) begin
                    state_n = ST_DONE;
                end else if (div_cnt_r == div_lat_r) begin
                    enable_n   = 1'b1;
                    div_cnt_n  = {DIV_W{1'b0}};
                    samp_cnt_n = samp_cnt_r + CNT_ONE;
                    last_n     = (samp_cnt_r == len_lat_r);
                end else begin
                    div_cnt_n = div_cnt_r + DIV_ONE;
                end
            end
            ST_DONE: begin
                if (Ack_i) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs are decoded from the next state so they align with it
    always_ff @(posedge Fg_CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_r    <= ST_IDLE;
            div_cnt_r  <= {DIV_W{1'b0}};
            samp_cnt_r <= {CNT_W{1'b0}};
            last_r     <= 1'b0;
            div_lat_r  <= {DIV_W{1'b0}};
            len_lat_r  <= {CNT_W{1'b0}};
            mode_r     <= {MODE_W{1'b0}};
            ready_r    <= 1'b1;
            enable_r   <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            div_cnt_r  <= div_cnt_n;
            samp_cnt_r <= samp_cnt_n;
            last_r     <= last_n;
            div_lat_r  <= div_lat_n;
            len_lat_r  <= len_lat_n;
            mode_r     <= mode_n;
            ready_r    <= (state_n == ST_IDLE);
            enable_r   <= enable_n;
            done_r     <= (state_n == ST_DONE);
        end
    end

    assign Ready  = ready_r;
    assign Enable = enable_r;
    assign Done   = done_r;
    assign Mode   = mode_r;

endmodule

// File: doc/sampling_control_mc.md
# sampling_control_mc

Parametrised sampling controller for the DDS capture path. It conditions the raw front-panel button into short-press and long-press events. A short press cycles the sampling mode. A long press starts or aborts a capture run that issues a programmable number of sample-enable strobes at a programmable clock-divided rate, and the run ends with a Done/Ack handshake to the downstream consumer.

## Interface
- `N_MODES`, 4: number of sampling modes, at least 2.
- `MODE_W`, 2: width of Mode, wide enough for N_MODES-1.
- `DEB_CYCLES`, 16: debounce stability window in clocks.
- `LONG_CYCLES`, 1024: debounced hold time that makes a long press.
- `DIV_W`, 16: width of the sample-period register.
- `CNT_W`, 10: width of the sample-count register.

Ports:
- `Fg_CLK` in 1: single system clock, rising edge.
- `RESETn` in 1: asynchronous, active-low reset.
- `IntBTN` in 1: raw asynchronous button, active high.
- `Div_i` in DIV_W: sample period minus 1, in clocks.
- `Len_i` in CNT_W: samples per run minus 1.
- `Ack_i` in 1: downstream acknowledge of Done.
- `Ready` out 1: high while IDLE.
- `Enable` out 1: one-clock sample strobe.
- `Done` out 1: run complete, held until acknowledged.
- `Mode` out MODE_W: current sampling mode.

## Operation
- Button path: 2-flop synchroniser, then debouncer. The debounced level changes only after the synchronised input has differed from it for DEB_CYCLES consecutive clocks.
- Press timer starts on the debounced rise and saturates at LONG_CYCLES.
  - Long event: one pulse when the timer reaches LONG_CYCLES while still held.
  - Short event: one pulse on the debounced fall, only if no long event fired during that press.
- FSM states: IDLE, SAMPLE, DONE.
- IDLE:
  - Short event: Mode increments. Mode N_MODES-1 wraps to 0.
  - Long event: go to SAMPLE. Div_i and Len_i are latched; the divider and sample counters clear.
- SAMPLE:
  - Divider counts 0..Div_i. At Div_i, Enable pulses, the divider clears and the sample counter increments.
  - After strobe number Len_i+1, go to DONE.
  - Long event: abort to IDLE. Done is not asserted, and the strobe scheduled in that cycle is suppressed.
  - Short events are ignored; Mode is frozen.
- DONE: Done=1. Ack_i=1 returns to IDLE. Button events are ignored.
- Ack_i outside DONE has no effect.
- Changes to Div_i or Len_i during a run have no effect until the next run.

## Timing
- Reset values, all asynchronous: state IDLE, Ready=1, Enable=0, Done=0, Mode=0. Debouncer level 0, all counters 0.
- Reset asserted mid-run forces the reset values immediately. No strobe is emitted after reset assertion.
- All outputs are registered.
- Button latency: 2 synchroniser clocks plus DEB_CYCLES to the debounced edge. Events and Mode change follow 1 clock later.
- Cycle 0 is the first clock with the state equal to SAMPLE. Ready falls in cycle 0.
- Enable is high in cycles k·(Div_i+1) for k = 1..Len_i+1.
- Div_i=0 gives Enable in every cycle from cycle 1 through cycle Len_i+1.
- DONE is entered, and Done rises, the clock after the last strobe.
- Ack_i sampled high in DONE: next clock Done=0, Ready=1.
- The long event after release is not followed by a short event, so a long press never changes Mode.

## Configuration
- `SAMPLING_CONTROL_DEBOUNCE_EN`
  - Defined: the debouncer is present as described above.
  - Undefined: the synchroniser output is used directly as the debounced level and DEB_CYCLES is unused. Button latency is 2 clocks plus 1.

## Test plan
Parameters for all scenarios: N_MODES=3, DEB_CYCLES=4, LONG_CYCLES=32, debounce enabled.
- Reset: RESETn=0 at any time -> Ready=1, Enable=0, Done=0, Mode=0.
- Mode cycling: three presses of 10 clocks each, 20 clocks apart -> Mode 1, 2, 0. Each change lands 2+4+1 clocks after the release edge.
- Bounce rejection: IntBTN pulses of 2 clocks, repeated 5 times with 2-clock gaps -> Mode unchanged.
- Full run: Div_i=3, Len_i=4, 40-clock press -> Ready falls, exactly 5 Enable pulses 4 clocks apart, Done 1 clock after the 5th. Mode is unchanged after release. Ack_i -> Done=0 and Ready=1 next clock.
- Abort: same setup, second long press after 2 strobes -> IDLE, Done never asserted, no further Enable.
- Reset mid-run: RESETn low after the 3rd strobe -> all outputs at reset values immediately. A new long press runs a full 5-strobe sequence.
